// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled in one interface.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, m_done, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_req, m_write, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, m_done, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_req, m_write, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Saturating count of consecutive D grants made while a fetch was waiting.
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic                at_limit,
  output logic [STREAK_W-1:0] count
);
  localparam logic [STREAK_W-1:0] LIMIT_C = STREAK_W'(LIMIT);
  localparam logic [STREAK_W-1:0] ONE_C   = {{(STREAK_W-1){1'b0}}, 1'b1};

  logic [STREAK_W-1:0] count_r;

  // counter register; clear wins over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {STREAK_W{1'b0}};
    end else if (clr) begin
      count_r <= {STREAK_W{1'b0}};
    end else if (inc && (count_r != LIMIT_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign at_limit = (count_r == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-fetch and D accesses onto one variable-latency memory port,
// D first, with a streak guard that eventually forces a waiting fetch ahead.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);
  state_e              state_r;
  owner_e              owner_r;
  logic                i_ready_r;
  logic                d_ready_r;
  logic [DATA_W-1:0]   i_rdata_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                m_req_r;
  logic                m_write_r;
  logic [ADDR_W-1:0]   m_addr_r;
  logic [DATA_W-1:0]   m_wdata_r;
  logic                busy_r;

  logic                any_req_s;
  logic                grant_i_s;
  logic                inc_s;
  logic                clr_s;
  logic                at_limit_s;
  logic [STREAK_W-1:0] streak_s;

  mem_arb_streak_ctr #(.LIMIT(STARVE_LIMIT)) u_streak (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc_s),
    .clr      (clr_s),
    .at_limit (at_limit_s),
    .count    (streak_s)
  );

  // grant decision and streak update, only meaningful in IDLE
  always_comb begin
    any_req_s = bus.i_req | bus.d_req;
    grant_i_s = 1'b0;
    inc_s     = 1'b0;
    clr_s     = 1'b0;
    if (bus.i_req && (!bus.d_req || at_limit_s)) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
    end
    if ((state_r == IDLE) && any_req_s) begin
      inc_s = !grant_i_s && bus.i_req;
      clr_s = grant_i_s || !bus.i_req;
    end else begin
      inc_s = 1'b0;
      clr_s = 1'b0;
    end
  end

  // access FSM with latched memory command and registered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      owner_r   <= OWN_I;
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      i_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r <= {DATA_W{1'b0}};
      m_req_r   <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          i_ready_r <= 1'b0;
          d_ready_r <= 1'b0;
          if (any_req_s) begin
            state_r   <= BUSY;
            m_req_r   <= 1'b1;
            busy_r    <= 1'b1;
            if (grant_i_s) begin
              owner_r   <= OWN_I;
              m_addr_r  <= bus.i_addr;
              m_write_r <= 1'b0;
              m_wdata_r <= {DATA_W{1'b0}};
            end else begin
              owner_r   <= OWN_D;
              m_addr_r  <= bus.d_addr;
              m_write_r <= bus.d_write;
              m_wdata_r <= bus.d_write ? bus.d_wdata : {DATA_W{1'b0}};
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.m_done) begin
            state_r <= RESP;
            m_req_r <= 1'b0;
            if (owner_r == OWN_I) begin
              i_rdata_r <= bus.m_rdata;
              i_ready_r <= 1'b1;
            end else begin
              // store completions leave d_rdata untouched
              if (!m_write_r) begin
                d_rdata_r <= bus.m_rdata;
              end else begin
                d_rdata_r <= d_rdata_r;
              end
              d_ready_r <= 1'b1;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          i_ready_r <= 1'b0;
          d_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          i_ready_r <= 1'b0;
          d_ready_r <= 1'b0;
          m_req_r   <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ready = i_ready_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.d_ready = d_ready_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.m_req   = m_req_r;
  assign bus.m_write = m_write_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [79:0] seq;
    logic [79:0] seq_exp;
    int          n_grants;
    int          both_hi;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.i_req = 1'b0;   bus.i_addr = 32'h0;
    bus.d_req = 1'b0;   bus.d_write = 1'b0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.m_done = 1'b0;  bus.m_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_m_req", 80'(bus.m_req), 80'd0);
    chk("rst_busy", 80'(bus.busy), 80'd0);
    chk("rst_i_rdata", 80'(bus.i_rdata), 80'd0);
    chk("rst_d_rdata", 80'(bus.d_rdata), 80'd0);
    chk("rst_m_addr", 80'(bus.m_addr), 80'd0);

    // I read, m_done on the second BUSY cycle
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    tick();
    chk("ird_m_req", 80'(bus.m_req), 80'd1);
    chk("ird_m_addr", 80'(bus.m_addr), 80'h40);
    chk("ird_m_write", 80'(bus.m_write), 80'd0);
    tick();
    chk("ird_still_busy", 80'(bus.m_req), 80'd1);
    bus.m_done = 1'b1; bus.m_rdata = 32'h00500093;
    tick();
    chk("ird_i_ready", 80'(bus.i_ready), 80'd1);
    chk("ird_d_ready", 80'(bus.d_ready), 80'd0);
    chk("ird_m_req_resp", 80'(bus.m_req), 80'd0);
    chk("ird_i_rdata", 80'(bus.i_rdata), 80'h00500093);
    bus.m_done = 1'b0; bus.i_req = 1'b0;
    tick();
    chk("ird_i_ready_off", 80'(bus.i_ready), 80'd0);
    chk("ird_rdata_held", 80'(bus.i_rdata), 80'h00500093);
    chk("ird_idle_busy", 80'(bus.busy), 80'd0);

    // D write, 3 BUSY cycles
    bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
    tick();
    chk("dwr_m_req1", 80'(bus.m_req), 80'd1);
    chk("dwr_m_addr", 80'(bus.m_addr), 80'h100);
    chk("dwr_m_write", 80'(bus.m_write), 80'd1);
    chk("dwr_m_wdata", 80'(bus.m_wdata), 80'hDEADBEEF);
    tick();
    chk("dwr_m_req2", 80'(bus.m_req), 80'd1);
    tick();
    chk("dwr_m_req3", 80'(bus.m_req), 80'd1);
    bus.m_done = 1'b1; bus.m_rdata = 32'h12345678;
    tick();
    chk("dwr_d_ready", 80'(bus.d_ready), 80'd1);
    chk("dwr_m_req_off", 80'(bus.m_req), 80'd0);
    chk("dwr_d_rdata", 80'(bus.d_rdata), 80'd0);
    bus.m_done = 1'b0; bus.d_req = 1'b0; bus.d_write = 1'b0;
    tick();
    chk("dwr_d_ready_off", 80'(bus.d_ready), 80'd0);

    // spurious m_done in IDLE
    bus.m_done = 1'b1; bus.m_rdata = 32'h0BAD0BAD;
    tick();
    chk("sp_idle_busy", 80'(bus.busy), 80'd0);
    chk("sp_idle_ready", 80'({bus.i_ready, bus.d_ready}), 80'd0);
    chk("sp_idle_i_rdata", 80'(bus.i_rdata), 80'h00500093);
    chk("sp_idle_d_rdata", 80'(bus.d_rdata), 80'd0);
    bus.m_done = 1'b0;

    // back-to-back D loads, spurious m_done held through RESP
    bus.d_req = 1'b1; bus.d_addr = 32'h10;
    tick();
    chk("ld1_m_addr", 80'(bus.m_addr), 80'h10);
    bus.m_done = 1'b1; bus.m_rdata = 32'hAAAA0001;
    tick();
    chk("ld1_d_ready", 80'(bus.d_ready), 80'd1);
    chk("ld1_d_rdata", 80'(bus.d_rdata), 80'hAAAA0001);
    chk("ld1_streak", 80'(dut.streak_s), 80'd0);
    bus.d_addr = 32'h14; bus.m_rdata = 32'h0BAD0BAD;
    tick();
    chk("ld1_idle", 80'(bus.busy), 80'd0);
    chk("ld1_no_extra_ready", 80'(bus.d_ready), 80'd0);
    chk("ld1_rdata_kept", 80'(bus.d_rdata), 80'hAAAA0001);
    bus.m_done = 1'b0;
    tick();
    chk("ld2_m_addr", 80'(bus.m_addr), 80'h14);
    bus.m_done = 1'b1; bus.m_rdata = 32'hAAAA0002;
    tick();
    chk("ld2_d_ready", 80'(bus.d_ready), 80'd1);
    chk("ld2_d_rdata", 80'(bus.d_rdata), 80'hAAAA0002);
    chk("ld2_streak", 80'(dut.streak_s), 80'd0);
    bus.d_req = 1'b0; bus.m_done = 1'b0;
    tick();

    // contention, m_done held high
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    bus.m_done = 1'b1; bus.m_rdata = 32'h5;
    seq = 80'd0; n_grants = 0; both_hi = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.i_ready && bus.d_ready) both_hi++;
      if (bus.i_ready) begin seq = {seq[71:0], 8'h49}; n_grants++; end
      if (bus.d_ready) begin seq = {seq[71:0], 8'h44}; n_grants++; end
      if (n_grants >= 10) break;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_done = 1'b0;
    seq_exp = "DDDDIDDDDI";
    chk("cont_count", 80'(n_grants), 80'd10);
    chk("cont_seq", seq, seq_exp);
    chk("cont_both_ready", 80'(both_hi), 80'd0);
    tick();

    // reset during a D read in flight
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h200;
    tick();
    chk("rb_busy", 80'(bus.busy), 80'd1);
    reset = 1'b1; bus.m_done = 1'b1; bus.m_rdata = 32'h77;
    tick();
    reset = 1'b0; bus.d_req = 1'b0;
    chk("rb_m_req", 80'(bus.m_req), 80'd0);
    chk("rb_m_addr", 80'(bus.m_addr), 80'd0);
    chk("rb_d_rdata", 80'(bus.d_rdata), 80'd0);
    chk("rb_i_rdata", 80'(bus.i_rdata), 80'd0);
    tick();
    chk("rb_no_d_ready", 80'(bus.d_ready), 80'd0);
    chk("rb_idle", 80'(bus.busy), 80'd0);
    chk("rb_d_rdata_after", 80'(bus.d_rdata), 80'd0);
    tick();
    chk("rb_no_d_ready2", 80'(bus.d_ready), 80'd0);
    bus.m_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
